id_stage_fwd: RTL and testbench

Registered, parametrised instruction-decode stage for the pipelined RV32I core: next generation of the combinational decoder. It decodes one instruction per cycle and resolves operands through NUM_FWD prioritised forwarding sources. It detects load-use hazards and stalls the fetch side with a valid/ready handshake. Decoded fields are held in an internal ID/EX register with flush support, and stall cycles are counted for performance monitoring.

---
 rtl/id_stage_fwd.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_id_stage_fwd.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_fwd.sv
// id_stage_fwd: registered RV32I decode stage with prioritised operand forwarding,
// load-use stall handshake towards fetch, flushable ID/EX register and stall counter.
module id_stage_fwd #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               instr,
    input  logic [XLEN-1:0]           pc,
    output logic [4:0]                rs1_addr,
    output logic [4:0]                rs2_addr,
    input  logic [XLEN-1:0]           rs1_rdata,
    input  logic [XLEN-1:0]           rs2_rdata,
    input  logic                      flush,
    input  logic [NUM_FWD-1:0]        fwd_wen,
    input  logic [5*NUM_FWD-1:0]      fwd_addr,
    input  logic [XLEN*NUM_FWD-1:0]   fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_is_load,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                alu_op,
    output logic                      alu_sub,
    output logic                      alu_sra,
    output logic [XLEN-1:0]           op1,
    output logic [XLEN-1:0]           op2,
    output logic [XLEN-1:0]           jmp_base,
    output logic [XLEN-1:0]           jmp_off,
    output logic [2:0]                jmp_flag,
    output logic [2:0]                load_code,
    output logic [2:0]                store_code,
    output logic [4:0]                rd_addr,
    output logic                      rd_wen,
    output logic                      illegal,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;

    localparam logic [2:0] JF_UNCOND = 3'b010;
    localparam logic [2:0] JF_NONE   = 3'b011;
    localparam logic [2:0] MEM_NONE  = 3'b111;

    // Returns {is_load, data}; lowest index wins, x0 is hard-wired to zero.
    function automatic logic [XLEN:0] fwd_pick(input logic [4:0] a,
                                                input logic [XLEN-1:0] rf);
        logic [XLEN:0] res;
        logic          hit;
        res = {1'b0, rf};
        hit = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!hit && fwd_wen[i] && (fwd_addr[5*i +: 5] == a)) begin
                hit = 1'b1;
                res = {fwd_is_load[i], fwd_data[XLEN*i +: XLEN]};
            end
        end
        if (a == 5'd0) begin
            res = '0;
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [4:0]      w_rd;
    logic            w_f7b5;
    logic            w_legal;
    logic            w_use1;
    logic            w_use2;
    logic            w_writes_rd;
    logic [XLEN:0]   w_fwd1;
    logic [XLEN:0]   w_fwd2;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;
    logic            w_hazard;
    logic            w_advance;
    logic            w_accept;

    logic signed [XLEN-1:0] w_imm_i;
    logic signed [XLEN-1:0] w_imm_s;
    logic signed [XLEN-1:0] w_imm_b;
    logic signed [XLEN-1:0] w_imm_j;
    logic signed [XLEN-1:0] w_imm_u;

    assign w_opc  = instr[6:0];
    assign w_f3   = instr[14:12];
    assign w_rd   = instr[11:7];
    assign w_f7b5 = instr[30];

    assign w_imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign w_imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign w_imm_u = XLEN'($signed({instr[31:12], 12'b0}));

    always_comb begin
        w_legal = 1'b0;
        case (w_opc)
            OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL: w_legal = 1'b1;
            OP_JALR: w_legal = (w_f3 == 3'b000);
            OP_LD:   w_legal = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
            OP_ST:   w_legal = (w_f3 <= 3'b010);
            OP_BR:   w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
            default: w_legal = 1'b0;
        endcase
    end

    assign w_use1 = w_legal && ((w_opc == OP_R)  || (w_opc == OP_I)  || (w_opc == OP_LD) ||
                                (w_opc == OP_ST) || (w_opc == OP_BR) || (w_opc == OP_JALR));
    assign w_use2 = w_legal && ((w_opc == OP_R)  || (w_opc == OP_ST) || (w_opc == OP_BR));
    assign w_writes_rd = w_legal && (w_opc != OP_ST) && (w_opc != OP_BR);

    assign rs1_addr = w_use1 ? instr[19:15] : 5'd0;
    assign rs2_addr = w_use2 ? instr[24:20] : 5'd0;

    // Unused operands resolve through x0, so they can never raise a hazard.
    assign w_fwd1   = fwd_pick(rs1_addr, rs1_rdata);
    assign w_fwd2   = fwd_pick(rs2_addr, rs2_rdata);
    assign w_rs1    = w_fwd1[XLEN-1:0];
    assign w_rs2    = w_fwd2[XLEN-1:0];
    assign w_hazard = w_fwd1[XLEN] | w_fwd2[XLEN];

    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance & ~w_hazard & ~flush;
    assign w_accept  = in_valid & in_ready;

    logic [2:0]      w_alu_op;
    logic            w_alu_sub;
    logic            w_alu_sra;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [XLEN-1:0] w_jmp_base;
    logic [XLEN-1:0] w_jmp_off;
    logic [2:0]      w_jmp_flag;
    logic [2:0]      w_load_code;
    logic [2:0]      w_store_code;
    logic [4:0]      w_rd_addr;
    logic            w_rd_wen;

    always_comb begin
        w_alu_op     = 3'b000;
        w_alu_sub    = 1'b0;
        w_alu_sra    = 1'b0;
        w_op1        = '0;
        w_op2        = '0;
        w_jmp_base   = '0;
        w_jmp_off    = '0;
        w_jmp_flag   = JF_NONE;
        w_load_code  = MEM_NONE;
        w_store_code = MEM_NONE;
        w_rd_addr    = 5'd0;
        w_rd_wen     = 1'b0;
        if (w_legal) begin
            case (w_opc)
                OP_R: begin
                    w_alu_op  = w_f3;
                    w_alu_sub = w_f7b5;
                    w_alu_sra = (w_f3 == 3'b101) && w_f7b5;
                    w_op1     = w_rs1;
                    w_op2     = w_rs2;
                end
                OP_I: begin
                    w_alu_op  = w_f3;
                    w_alu_sra = (w_f3 == 3'b101) && w_f7b5;
                    w_op1     = w_rs1;
                    w_op2     = w_imm_i;
                end
                OP_LUI: begin
                    w_op1 = w_imm_u;
                end
                OP_AUIPC: begin
                    w_op1 = pc;
                    w_op2 = w_imm_u;
                end
                OP_JAL: begin
                    w_op1      = pc;
                    w_op2      = XLEN'(4);
                    w_jmp_base = pc;
                    w_jmp_off  = w_imm_j;
                    w_jmp_flag = JF_UNCOND;
                end
                OP_JALR: begin
                    w_op1      = pc;
                    w_op2      = XLEN'(4);
                    w_jmp_base = w_rs1;
                    w_jmp_off  = w_imm_i;
                    w_jmp_flag = JF_UNCOND;
                end
                OP_BR: begin
                    w_op1      = w_rs1;
                    w_op2      = w_rs2;
                    w_jmp_base = pc;
                    w_jmp_off  = w_imm_b;
                    w_jmp_flag = w_f3;
                end
                OP_LD: begin
                    w_op1       = w_rs1;
                    w_op2       = w_imm_i;
                    w_load_code = w_f3;
                end
                OP_ST: begin
                    w_op1        = w_rs1;
                    w_op2        = w_imm_s;
                    w_store_code = w_f3;
                end
                default: begin
                    w_op1 = '0;
                end
            endcase
            if (w_writes_rd && (w_rd != 5'd0)) begin
                w_rd_addr = w_rd;
                w_rd_wen  = 1'b1;
            end
        end
    end

    // ID/EX register boundary
    logic            r_out_valid;
    logic [2:0]      r_alu_op;
    logic            r_alu_sub;
    logic            r_alu_sra;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [XLEN-1:0] r_jmp_base;
    logic [XLEN-1:0] r_jmp_off;
    logic [2:0]      r_jmp_flag;
    logic [2:0]      r_load_code;
    logic [2:0]      r_store_code;
    logic [4:0]      r_rd_addr;
    logic            r_rd_wen;
    logic            r_illegal;
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_alu_op     <= 3'b000;
            r_alu_sub    <= 1'b0;
            r_alu_sra    <= 1'b0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_jmp_base   <= '0;
            r_jmp_off    <= '0;
            r_jmp_flag   <= JF_NONE;
            r_load_code  <= MEM_NONE;
            r_store_code <= MEM_NONE;
            r_rd_addr    <= 5'd0;
            r_rd_wen     <= 1'b0;
            r_illegal    <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_alu_op     <= w_alu_op;
                r_alu_sub    <= w_alu_sub;
                r_alu_sra    <= w_alu_sra;
                r_op1        <= w_op1;
                r_op2        <= w_op2;
                r_jmp_base   <= w_jmp_base;
                r_jmp_off    <= w_jmp_off;
                r_jmp_flag   <= w_jmp_flag;
                r_load_code  <= w_load_code;
                r_store_code <= w_store_code;
                r_rd_addr    <= w_rd_addr;
                r_rd_wen     <= w_rd_wen;
                r_illegal    <= ~w_legal;
            end else if (w_advance) begin
                r_out_valid <= 1'b0;
            end
            if (in_valid && w_hazard && !flush) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign alu_op     = r_alu_op;
    assign alu_sub    = r_alu_sub;
    assign alu_sra    = r_alu_sra;
    assign op1        = r_op1;
    assign op2        = r_op2;
    assign jmp_base   = r_jmp_base;
    assign jmp_off    = r_jmp_off;
    assign jmp_flag   = r_jmp_flag;
    assign load_code  = r_load_code;
    assign store_code = r_store_code;
    assign rd_addr    = r_rd_addr;
    assign rd_wen     = r_rd_wen;
    assign illegal    = r_illegal;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Self-checking bench for id_stage_fwd: decode vector table, directed
// forwarding/stall/backpressure/flush/reset sequences, randomized run vs a reference model.
module tb_id_stage_fwd;

    localparam int NF = 2;
    localparam int CW = 4;

    typedef struct packed {
        logic [2:0]  aop;
        logic        sub;
        logic        sra;
        logic [31:0] o1;
        logic [31:0] o2;
        logic [31:0] jb;
        logic [31:0] jo;
        logic [2:0]  jf;
        logic [2:0]  lc;
        logic [2:0]  sc;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        dec_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instr, pc, rs1_rdata, rs2_rdata;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [NF-1:0] fwd_wen, fwd_is_load;
    logic [5*NF-1:0] fwd_addr;
    logic [32*NF-1:0] fwd_data;
    logic [2:0]  alu_op, jmp_flag, load_code, store_code;
    logic        alu_sub, alu_sra, rd_wen, illegal;
    logic [31:0] op1, op2, jmp_base, jmp_off;
    logic [CW-1:0] stall_cnt;

    logic [31:0] regs [32];
    logic        fw_en [NF];
    logic        fw_ld [NF];
    logic [4:0]  fw_ad [NF];
    logic [31:0] fw_dt [NF];

    int n_chk  = 0;
    int n_fail = 0;

    id_stage_fwd #(.XLEN(32), .NUM_FWD(NF), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .flush(flush),
        .fwd_wen(fwd_wen), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .fwd_is_load(fwd_is_load), .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .alu_sub(alu_sub), .alu_sra(alu_sra), .op1(op1), .op2(op2),
        .jmp_base(jmp_base), .jmp_off(jmp_off), .jmp_flag(jmp_flag),
        .load_code(load_code), .store_code(store_code), .rd_addr(rd_addr),
        .rd_wen(rd_wen), .illegal(illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign rs1_rdata   = regs[rs1_addr];
    assign rs2_rdata   = regs[rs2_addr];
    assign fwd_wen     = {fw_en[1], fw_en[0]};
    assign fwd_is_load = {fw_ld[1], fw_ld[0]};
    assign fwd_addr    = {fw_ad[1], fw_ad[0]};
    assign fwd_data    = {fw_dt[1], fw_dt[0]};

    function automatic dec_t mk(input logic [2:0] aop, input logic sub, input logic sra,
                                input logic [31:0] o1, input logic [31:0] o2,
                                input logic [31:0] jb, input logic [31:0] jo,
                                input logic [2:0] jf, input logic [2:0] lc, input logic [2:0] sc,
                                input logic [4:0] rd, input logic wen, input logic ill);
        dec_t d;
        d = '{aop, sub, sra, o1, o2, jb, jo, jf, lc, sc, rd, wen, ill};
        return d;
    endfunction

    function automatic dec_t dut_dec();
        dec_t d;
        d = '{alu_op, alu_sub, alu_sra, op1, op2, jmp_base, jmp_off,
              jmp_flag, load_code, store_code, rd_addr, rd_wen, illegal};
        return d;
    endfunction

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Value seen for a register: youngest matching producer, else the register file.
    task automatic src_val(input logic [4:0] a, output logic [31:0] v, output logic ld);
        v  = regs[a];
        ld = 1'b0;
        if (a == 5'd0) begin
            v = 32'd0;
        end else begin
            for (int i = NF - 1; i >= 0; i--) begin
                if (fw_en[i] && fw_ad[i] == a) begin
                    v  = fw_dt[i];
                    ld = fw_ld[i];
                end
            end
        end
    endtask

    task automatic ref_decode(input logic [31:0] ins, input logic [31:0] p, output dec_t e,
                              output logic [4:0] a1, output logic [4:0] a2, output logic hz);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] ii, is, ib, ij, iu, v1, v2;
        logic        l1, l2, ok, u1, u2;
        opc = ins[6:0];
        f3  = ins[14:12];
        ii  = 32'($signed(ins) >>> 20);
        is  = 32'($signed({ins[31:25], ins[11:7], 20'h0}) >>> 20);
        ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'h0}) >>> 19);
        ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'h0}) >>> 11);
        iu  = {ins[31:12], 12'h0};
        case (opc)
            7'h33, 7'h13, 7'h37, 7'h17, 7'h6F: ok = 1'b1;
            7'h67: ok = (f3 == 3'd0);
            7'h03: ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
            7'h23: ok = (f3 < 3'd3);
            7'h63: ok = (f3 != 3'd2) && (f3 != 3'd3);
            default: ok = 1'b0;
        endcase
        u1 = ok && (opc == 7'h33 || opc == 7'h13 || opc == 7'h03 || opc == 7'h23 ||
                    opc == 7'h63 || opc == 7'h67);
        u2 = ok && (opc == 7'h33 || opc == 7'h23 || opc == 7'h63);
        a1 = u1 ? ins[19:15] : 5'd0;
        a2 = u2 ? ins[24:20] : 5'd0;
        src_val(a1, v1, l1);
        src_val(a2, v2, l2);
        hz = l1 | l2;
        e = mk(3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd3, 3'd7, 3'd7, 5'd0, 1'b0, !ok);
        if (ok) begin
            case (opc)
                7'h33: begin e.aop = f3; e.sub = ins[30]; e.sra = (f3 == 3'd5) && ins[30];
                             e.o1 = v1; e.o2 = v2; end
                7'h13: begin e.aop = f3; e.sra = (f3 == 3'd5) && ins[30]; e.o1 = v1; e.o2 = ii; end
                7'h37: e.o1 = iu;
                7'h17: begin e.o1 = p; e.o2 = iu; end
                7'h6F: begin e.o1 = p; e.o2 = 32'd4; e.jb = p; e.jo = ij; e.jf = 3'd2; end
                7'h67: begin e.o1 = p; e.o2 = 32'd4; e.jb = v1; e.jo = ii; e.jf = 3'd2; end
                7'h63: begin e.o1 = v1; e.o2 = v2; e.jb = p; e.jo = ib; e.jf = f3; end
                7'h03: begin e.o1 = v1; e.o2 = ii; e.lc = f3; end
                default: begin e.o1 = v1; e.o2 = is; e.sc = f3; end
            endcase
            if (opc != 7'h23 && opc != 7'h63 && ins[11:7] != 5'd0) begin
                e.rd  = ins[11:7];
                e.wen = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        r[11:7]  = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 10))
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h37;
            3: r[6:0] = 7'h17;
            4: r[6:0] = 7'h6F;
            5: r[6:0] = 7'h67;
            6: r[6:0] = 7'h63;
            7: r[6:0] = 7'h03;
            8: r[6:0] = 7'h23;
            default: r[6:0] = r[6:0];
        endcase
        return r;
    endfunction

    vec_t tbl [16];
    dec_t d_rst, d_beq, d_add, d_sw, d_jalr, e_r, m_dec;
    logic [4:0] a1, a2;
    logic hz, exp_rdy, m_valid;
    int m_cnt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        d_rst  = mk(0, 0, 0, 0, 0, 0, 0, 3, 7, 7, 0, 0, 0);
        d_add  = mk(0, 0, 0, 5, 7, 0, 0, 3, 7, 7, 3, 1, 0);
        d_beq  = mk(0, 0, 0, 5, 7, 32'h300, 32'hFFFFFFF8, 0, 7, 7, 0, 0, 0);
        d_sw   = mk(0, 0, 0, 5, 20, 0, 0, 3, 7, 2, 0, 0, 0);
        d_jalr = mk(0, 0, 0, 32'h40, 4, 32'h100, 12, 2, 7, 7, 1, 1, 0);
        tbl[0]  = '{32'h002081B3, 32'h0,   d_add};
        tbl[1]  = '{32'h402081B3, 32'h0,   mk(0, 1, 0, 5, 7, 0, 0, 3, 7, 7, 3, 1, 0)};
        tbl[2]  = '{32'h4030D313, 32'h0,   mk(5, 0, 1, 5, 32'h403, 0, 0, 3, 7, 7, 6, 1, 0)};
        tbl[3]  = '{32'h123453B7, 32'h0,   mk(0, 0, 0, 32'h12345000, 0, 0, 0, 3, 7, 7, 7, 1, 0)};
        tbl[4]  = '{32'hFFFFF417, 32'h200, mk(0, 0, 0, 32'h200, 32'hFFFFF000, 0, 0, 3, 7, 7, 8, 1, 0)};
        tbl[5]  = '{32'h010000EF, 32'h80,  mk(0, 0, 0, 32'h80, 4, 32'h80, 16, 2, 7, 7, 1, 1, 0)};
        tbl[6]  = '{32'h00C280E7, 32'h40,  d_jalr};
        tbl[7]  = '{32'hFE208CE3, 32'h300, d_beq};
        tbl[8]  = '{32'hFFC12483, 32'h0,   mk(0, 0, 0, 7, 32'hFFFFFFFC, 0, 0, 3, 2, 7, 9, 1, 0)};
        tbl[9]  = '{32'h0020AA23, 32'h0,   d_sw};
        tbl[10] = '{32'h0020817F, 32'h0,   mk(0, 0, 0, 0, 0, 0, 0, 3, 7, 7, 0, 0, 1)};
        tbl[11] = '{32'h0000B183, 32'h0,   mk(0, 0, 0, 0, 0, 0, 0, 3, 7, 7, 0, 0, 1)};
        tbl[12] = '{32'h00108013, 32'h0,   mk(0, 0, 0, 5, 1, 0, 0, 3, 7, 7, 0, 0, 0)};
        tbl[13] = '{32'h00C290E7, 32'h0,   mk(0, 0, 0, 0, 0, 0, 0, 3, 7, 7, 0, 0, 1)};
        tbl[14] = '{32'hFE20ACE3, 32'h0,   mk(0, 0, 0, 0, 0, 0, 0, 3, 7, 7, 0, 0, 1)};
        tbl[15] = '{32'h0020B533, 32'h0,   mk(3, 0, 0, 5, 7, 0, 0, 3, 7, 7, 10, 1, 0)};

        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
        regs[0] = 32'hDEADBEEF;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        regs[5] = 32'h100;
        for (int i = 0; i < NF; i++) begin
            fw_en[i] = 1'b0; fw_ld[i] = 1'b0; fw_ad[i] = 5'd0; fw_dt[i] = 32'd0;
        end
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instr = 32'd0; pc = 32'd0;
        step();
        step();
        check("reset_valid", out_valid, 1'b0);
        check("reset_cnt", stall_cnt, 0);
        check("reset_fields", dut_dec(), d_rst);
        rst = 1'b0;

        // Decode table
        for (int k = 0; k < 16; k++) begin
            instr = tbl[k].ins; pc = tbl[k].pc; in_valid = 1'b1;
            #1;
            check($sformatf("tbl%0d_ready", k), in_ready, 1'b1);
            step();
            check($sformatf("tbl%0d_valid", k), out_valid, 1'b1);
            check($sformatf("tbl%0d_dec", k), dut_dec(), tbl[k].e);
        end

        // Forwarding priority and x0
        fw_en[0] = 1; fw_en[1] = 1; fw_ad[0] = 1; fw_ad[1] = 1;
        fw_dt[0] = 32'hAAAA; fw_dt[1] = 32'hBBBB;
        instr = 32'hFFF08213; pc = 0;
        step();
        check("fwd_prio_op1", op1, 32'hAAAA);
        check("fwd_prio_op2", op2, 32'hFFFFFFFF);
        instr = 32'hFFF00213;
        step();
        check("fwd_x0_op1", op1, 32'd0);
        fw_en[0] = 0; instr = 32'hFFF08213;
        step();
        check("fwd_src1_op1", op1, 32'hBBBB);
        fw_en[1] = 0;

        // Load-use stall on SW rs2
        fw_en[0] = 1; fw_ad[0] = 2; fw_ld[0] = 1; fw_dt[0] = 32'h55;
        instr = 32'h0020AA23;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_ready", c), in_ready, 1'b0);
            step();
            check($sformatf("stall%0d_bubble", c), out_valid, 1'b0);
        end
        check("stall_cnt3", stall_cnt, 3);
        fw_ld[0] = 0;
        #1;
        check("stall_release_ready", in_ready, 1'b1);
        step();
        check("stall_sw_valid", out_valid, 1'b1);
        check("stall_sw_dec", dut_dec(), d_sw);
        fw_en[0] = 0;

        // Backpressure with a held BEQ
        instr = 32'hFE208CE3; pc = 32'h300;
        step();
        out_ready = 0; instr = 32'h002081B3; pc = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("hold%0d_ready", c), in_ready, 1'b0);
            step();
            check($sformatf("hold%0d_valid", c), out_valid, 1'b1);
            check($sformatf("hold%0d_dec", c), dut_dec(), d_beq);
        end
        out_ready = 1;
        #1;
        check("hold_release_ready", in_ready, 1'b1);
        step();
        check("hold_next_dec", dut_dec(), d_add);

        // JALR then flush while held
        instr = 32'h00C280E7; pc = 32'h40;
        step();
        check("jalr_dec", dut_dec(), d_jalr);
        out_ready = 0; in_valid = 0; flush = 1;
        #1;
        check("flush_ready", in_ready, 1'b0);
        step();
        check("flush_valid", out_valid, 1'b0);
        flush = 0; out_ready = 1;

        // Reset in the middle of a stall
        fw_en[0] = 1; fw_ad[0] = 2; fw_ld[0] = 1;
        instr = 32'h0020AA23; in_valid = 1;
        step();
        step();
        check("midstall_cnt5", stall_cnt, 5);
        rst = 1;
        step();
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_cnt", stall_cnt, 0);
        check("rst_mid_fields", dut_dec(), d_rst);
        rst = 0; fw_en[0] = 0; fw_ld[0] = 0; in_valid = 0;

        // Randomized run against the reference model
        m_valid = 1'b0;
        m_cnt   = 0;
        m_dec   = d_rst;
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            pc        = $urandom & 32'hFFFFFFFC;
            instr     = rand_instr();
            for (int i = 0; i < NF; i++) begin
                fw_en[i] = $urandom_range(0, 1) != 0;
                fw_ad[i] = 5'($urandom_range(0, 7));
                fw_dt[i] = $urandom;
                fw_ld[i] = ($urandom_range(0, 3) == 0);
            end
            if (n % 64 == 0) regs[$urandom_range(0, 31)] = $urandom;
            #1;
            ref_decode(instr, pc, e_r, a1, a2, hz);
            exp_rdy = (!m_valid || out_ready) && !hz && !flush;
            check("rnd_ready", in_ready, exp_rdy);
            check("rnd_rs1_addr", rs1_addr, a1);
            check("rnd_rs2_addr", rs2_addr, a2);
            if (flush) m_valid = 1'b0;
            else if (in_valid && exp_rdy) begin m_valid = 1'b1; m_dec = e_r; end
            else if (!m_valid || out_ready) m_valid = 1'b0;
            if (in_valid && hz && !flush && m_cnt < (1 << CW) - 1) m_cnt++;
            step();
            check("rnd_valid", out_valid, m_valid);
            if (m_valid) check("rnd_dec", dut_dec(), m_dec);
            check("rnd_stall_cnt", stall_cnt, m_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
